// File: rtl/fc_mac16_acc.sv
// -----------------------------------------------------------------------------
// fc_mac16_acc
// Fully-connected neuron accumulator. Walks a 16-wide activation RAM and a
// weight memory block by block, multiplies the 16 lanes pairwise, accumulates
// the products over len blocks, then adds a bias, optionally applies ReLU and
// emits one saturated fixed-point neuron output.
//
// Ports
//   clk, rst      rising-edge clock, synchronous active-high reset
//   start         run request, accepted only while idle
//   base_addr     first activation word address
//   len           number of 16-word blocks (0 .. 2^(AWIDTH-4))
//   bias          signed fixed-point bias
//   relu_en       clamp negative results to zero
//   raddr         activation RAM read address (registered)
//   act_flat      16 activation lanes, lane j = word raddr+j
//   w_addr        weight memory row address (registered)
//   w_flat        16 weight lanes, same layout as act_flat
//   busy          high whenever the block is not idle
//   out_valid     one-cycle pulse marking a new result
//   result        saturated neuron output, held until the next out_valid
// -----------------------------------------------------------------------------
module fc_mac16_acc #(
   parameter int DWIDTH = 16,
   parameter int AWIDTH = 8,
   parameter int FRAC   = 8,
   parameter int ACCW   = 40
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic [AWIDTH-1:0]      base_addr,
   input  logic [AWIDTH-4:0]      len,
   input  logic [DWIDTH-1:0]      bias,
   input  logic                   relu_en,
   output logic [AWIDTH-1:0]      raddr,
   input  logic [16*DWIDTH-1:0]   act_flat,
   output logic [AWIDTH-1:0]      w_addr,
   input  logic [16*DWIDTH-1:0]   w_flat,
   output logic                   busy,
   output logic                   out_valid,
   output logic [DWIDTH-1:0]      result
);

   localparam int LANES = 16;
   localparam int PW    = 2 * DWIDTH;     // product width
   localparam int SW    = PW + 4;         // adder-tree sum width (16 terms)
   localparam int LW    = AWIDTH - 3;     // block-count width

   localparam logic [AWIDTH-1:0] BLK_STEP = AWIDTH'(LANES);
   localparam logic [LW-1:0]     LEN_ONE  = LW'(1);

   // Saturation bounds expressed at accumulator width
   localparam logic signed [ACCW-1:0] SMAX =
      {{(ACCW-DWIDTH+1){1'b0}}, {(DWIDTH-1){1'b1}}};
   localparam logic signed [ACCW-1:0] SMIN =
      {{(ACCW-DWIDTH+1){1'b1}}, {(DWIDTH-1){1'b0}}};

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DRAIN,
      S_DONE
   } state_t;

   state_t state_q, state_d;

   // FSM control strobes
   logic accept;     // start accepted this cycle
   logic run;        // a block address is being presented
   logic done;       // final result is formed this cycle

   // Sequencing counters
   logic [LW-1:0] cnt_q;     // blocks still to present, including the current one
   logic [1:0]    drn_q;     // cycles spent in DRAIN

   // Latched request parameters
   logic [AWIDTH-1:0] raddr_q;
   logic [AWIDTH-1:0] w_addr_q;
   logic [DWIDTH-1:0] bias_q;
   logic              relu_q;

   // Valid-tagged pipeline
   logic                    rd_vld_q;              // memory data valid this cycle
   logic                    p1_vld_q;              // products valid
   logic signed [PW-1:0]    prod_q [LANES];
   logic                    p2_vld_q;              // sum valid
   logic signed [SW-1:0]    sum_d, sum_q;
   logic signed [ACCW-1:0]  acc_q;

   // Output stage
   logic signed [ACCW-1:0]  bias_sh;
   logic signed [ACCW-1:0]  t_sum;
   logic signed [ACCW-1:0]  s_shr;
   logic [DWIDTH-1:0]       res_d;
   logic [DWIDTH-1:0]       result_q;
   logic                    out_valid_q;

   // --------------------------------------------------------------------------
   // FSM: state register
   // --------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // --------------------------------------------------------------------------
   // FSM: next-state logic
   // --------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = (len == '0) ? S_DRAIN : S_RUN;
            end
         end
         S_RUN: begin
            if (cnt_q == LEN_ONE) begin
               state_d = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (drn_q == 2'd2) begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // --------------------------------------------------------------------------
   // FSM: output logic
   // --------------------------------------------------------------------------
   always_comb begin
      busy   = (state_q != S_IDLE);
      accept = (state_q == S_IDLE) && start;
      run    = (state_q == S_RUN);
      done   = (state_q == S_DONE);
   end

   // --------------------------------------------------------------------------
   // Sequencing counters and request latches
   // --------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q    <= '0;
         drn_q    <= '0;
         raddr_q  <= '0;
         w_addr_q <= '0;
         bias_q   <= '0;
         relu_q   <= 1'b0;
      end else begin
         if (accept) begin
            cnt_q    <= len;
            raddr_q  <= base_addr;
            w_addr_q <= '0;
            bias_q   <= bias;
            relu_q   <= relu_en;
         end else if (run) begin
            cnt_q    <= cnt_q - LEN_ONE;
            raddr_q  <= raddr_q + BLK_STEP;     // wraps modulo 2^AWIDTH
            w_addr_q <= w_addr_q + AWIDTH'(1);
         end

         if (state_q == S_DRAIN) begin
            drn_q <= drn_q + 2'd1;
         end else begin
            drn_q <= '0;
         end
      end
   end

   // --------------------------------------------------------------------------
   // Pipeline stage 0/1: memory data valid one cycle after the address is
   // presented; register the 16 lane products.
   // --------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_vld_q <= 1'b0;
         p1_vld_q <= 1'b0;
         for (int unsigned j = 0; j < LANES; j++) begin
            prod_q[j] <= '0;
         end
      end else begin
         rd_vld_q <= run;
         p1_vld_q <= rd_vld_q;
         if (rd_vld_q) begin
            for (int unsigned j = 0; j < LANES; j++) begin
               prod_q[j] <= $signed(act_flat[DWIDTH*j +: DWIDTH])
                          * $signed(w_flat[DWIDTH*j +: DWIDTH]);
            end
         end
      end
   end

   // --------------------------------------------------------------------------
   // Pipeline stage 2: sign-extended sum of the 16 products
   // --------------------------------------------------------------------------
   always_comb begin
      sum_d = '0;
      for (int unsigned j = 0; j < LANES; j++) begin
         sum_d = sum_d + {{(SW-PW){prod_q[j][PW-1]}}, prod_q[j]};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         p2_vld_q <= 1'b0;
         sum_q    <= '0;
      end else begin
         p2_vld_q <= p1_vld_q;
         if (p1_vld_q) begin
            sum_q <= sum_d;
         end
      end
   end

   // --------------------------------------------------------------------------
   // Pipeline stage 3: accumulate. The pipeline is always empty when a new
   // request is accepted, so clearing on accept cannot drop a block.
   // --------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         acc_q <= '0;
      end else if (accept) begin
         acc_q <= '0;
      end else if (p2_vld_q) begin
         acc_q <= acc_q + {{(ACCW-SW){sum_q[SW-1]}}, sum_q};
      end
   end

   // --------------------------------------------------------------------------
   // Output: add bias aligned to the product scale, drop FRAC bits with an
   // arithmetic shift (rounds toward -inf), saturate, optional ReLU.
   // --------------------------------------------------------------------------
   always_comb begin
      bias_sh = {{(ACCW-DWIDTH-FRAC){bias_q[DWIDTH-1]}}, bias_q, {FRAC{1'b0}}};
      t_sum   = acc_q + bias_sh;
      s_shr   = t_sum >>> FRAC;
      if (s_shr > SMAX) begin
         res_d = SMAX[DWIDTH-1:0];
      end else if (s_shr < SMIN) begin
         res_d = SMIN[DWIDTH-1:0];
      end else begin
         res_d = s_shr[DWIDTH-1:0];
      end
      if (relu_q && s_shr[ACCW-1]) begin
         res_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         result_q    <= '0;
         out_valid_q <= 1'b0;
      end else begin
         out_valid_q <= done;
         if (done) begin
            result_q <= res_d;
         end
      end
   end

   assign raddr     = raddr_q;
   assign w_addr    = w_addr_q;
   assign out_valid = out_valid_q;
   assign result    = result_q;

endmodule

// File: tb/tb_fc_mac16_acc.sv
// -----------------------------------------------------------------------------
// tb_fc_mac16_acc
// Directed bench for fc_mac16_acc. Models the registered-read activation RAM
// and weight memory, pushes the expected result and its due cycle into a
// scoreboard queue when a run is started, and compares out_valid/result
// every cycle against the head of that queue.
// -----------------------------------------------------------------------------
module tb_fc_mac16_acc;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic [7:0]    base_addr;
   logic [4:0]    len;
   logic [15:0]   bias;
   logic          relu_en;
   logic [7:0]    raddr;
   logic [255:0]  act_flat;
   logic [7:0]    w_addr;
   logic [255:0]  w_flat;
   logic          busy;
   logic          out_valid;
   logic [15:0]   result;

   int checks = 0;
   int errors = 0;
   int ecnt   = 0;

   typedef struct {
      logic [15:0] res;
      int          cyc;
   } exp_t;

   exp_t sbq[$];

   logic [15:0] act_mem [256];
   logic [15:0] w_mem   [256][16];

   fc_mac16_acc #(
      .DWIDTH (16),
      .AWIDTH (8),
      .FRAC   (8),
      .ACCW   (40)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .base_addr (base_addr),
      .len       (len),
      .bias      (bias),
      .relu_en   (relu_en),
      .raddr     (raddr),
      .act_flat  (act_flat),
      .w_addr    (w_addr),
      .w_flat    (w_flat),
      .busy      (busy),
      .out_valid (out_valid),
      .result    (result)
   );

   always #5 clk = ~clk;

   always @(posedge clk) ecnt <= ecnt + 1;

   // Registered-read memories: address sampled at the edge, data next cycle
   always @(posedge clk) begin
      for (int j = 0; j < 16; j++) begin
         act_flat[16*j +: 16] <= act_mem[8'(int'(raddr) + j)];
         w_flat[16*j +: 16]   <= w_mem[w_addr][j];
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Scoreboard: out_valid must be high exactly in the due cycle of the head
   always @(negedge clk) begin
      if (sbq.size() != 0 && ecnt == sbq[0].cyc) begin
         chk("ov_due", {31'd0, out_valid}, 32'd1);
         chk("result", {16'd0, result}, {16'd0, sbq[0].res});
         void'(sbq.pop_front());
      end else begin
         chk("ov_idle", {31'd0, out_valid}, 32'd0);
      end
   end

   function automatic logic [15:0] model(input logic [7:0] b, input int l,
                                         input logic [15:0] bi, input logic re);
      longint acc = 0;
      longint t;
      longint s;
      logic [7:0] a;
      for (int i = 0; i < l; i++) begin
         for (int j = 0; j < 16; j++) begin
            a = b + 8'(16*i + j);
            acc += longint'($signed(act_mem[a])) * longint'($signed(w_mem[i][j]));
         end
      end
      t = acc + longint'($signed(bi)) * 256;
      s = t >>> 8;
      if (s > 32767) s = 32767;
      else if (s < -32768) s = -32768;
      if (re && s < 0) s = 0;
      return s[15:0];
   endfunction

   task automatic fill_const(input logic [15:0] a, input logic [15:0] w);
      for (int i = 0; i < 256; i++) begin
         act_mem[i] = a;
         for (int j = 0; j < 16; j++) w_mem[i][j] = w;
      end
   endtask

   task automatic fill_rand();
      for (int i = 0; i < 256; i++) begin
         act_mem[i] = 16'($urandom_range(1023)) - 16'd512;
         for (int j = 0; j < 16; j++) w_mem[i][j] = 16'($urandom_range(1023)) - 16'd512;
      end
   endtask

   // Drives start for one cycle (called at a negedge); returns at the next negedge
   task automatic start_op(input logic [7:0] b, input logic [4:0] l, input logic [15:0] bi,
                           input logic re, input bit push, input logic [15:0] exp,
                           output int c0);
      exp_t e;
      base_addr = b;
      len       = l;
      bias      = bi;
      relu_en   = re;
      start     = 1'b1;
      c0        = ecnt;
      if (push) begin
         e.res = exp;
         e.cyc = ecnt + int'(l) + 5;
         sbq.push_back(e);
      end
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_until(input int c);
      while (ecnt < c) @(negedge clk);
   endtask

   task automatic wait_empty(input int maxc);
      int n = 0;
      while (sbq.size() != 0 && n < maxc) begin
         @(negedge clk);
         n++;
      end
      if (sbq.size() != 0) begin
         checks++;
         errors++;
         $error("FAIL timeout observed=%0d pending expected=0", sbq.size());
         sbq.delete();
      end
      @(negedge clk);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog observed=running expected=finished");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int c0;
      logic [15:0] ea, ec, bi;

      rst = 1'b1; start = 1'b0; base_addr = '0; len = '0; bias = '0; relu_en = 1'b0;
      fill_const(16'h0000, 16'h0000);
      repeat (3) @(negedge clk);
      chk("rst_busy",   {31'd0, busy},   32'd0);
      chk("rst_result", {16'd0, result}, 32'd0);
      chk("rst_raddr",  {24'd0, raddr},  32'd0);
      chk("rst_waddr",  {24'd0, w_addr}, 32'd0);
      rst = 1'b0;
      @(negedge clk);

      // 1.0 * 1.0 over 16 lanes -> 16.0, busy in cycles 1..5, idle in cycle 6
      fill_const(16'h0100, 16'h0100);
      start_op(8'h00, 5'd1, 16'h0000, 1'b0, 1'b1, 16'h1000, c0);
      for (int k = 1; k <= 5; k++) begin
         chk("t1_busy", {31'd0, busy}, 32'd1);
         @(negedge clk);
      end
      chk("t1_idle", {31'd0, busy}, 32'd0);
      wait_empty(40);

      // 0.5 * 2.0, four blocks, bias 1.0 -> 65.0; address sequence
      fill_const(16'h0080, 16'h0200);
      start_op(8'h00, 5'd4, 16'h0100, 1'b0, 1'b1, 16'h4100, c0);
      for (int k = 0; k < 4; k++) begin
         chk("t2_raddr", {24'd0, raddr},  32'(16*k));
         chk("t2_waddr", {24'd0, w_addr}, 32'(k));
         @(negedge clk);
      end
      wait_empty(40);

      // Saturation and ReLU
      fill_const(16'h7FFF, 16'h7FFF);
      start_op(8'h00, 5'd1, 16'h0000, 1'b0, 1'b1, 16'h7FFF, c0);
      wait_empty(40);
      fill_const(16'h7FFF, 16'h8001);
      start_op(8'h00, 5'd1, 16'h0000, 1'b0, 1'b1, 16'h8000, c0);
      wait_empty(40);
      start_op(8'h00, 5'd1, 16'h0000, 1'b1, 1'b1, 16'h0000, c0);
      wait_empty(40);

      // Address wrap
      fill_rand();
      bi = 16'h0340;
      ea = model(8'hF8, 2, bi, 1'b0);
      start_op(8'hF8, 5'd2, bi, 1'b0, 1'b1, ea, c0);
      chk("wrap_raddr0", {24'd0, raddr}, 32'h0000_00F8);
      @(negedge clk);
      chk("wrap_raddr1", {24'd0, raddr}, 32'h0000_0008);
      wait_empty(40);

      // len = 0: bias only, latency 5
      start_op(8'h00, 5'd0, 16'hFE80, 1'b0, 1'b1, 16'hFE80, c0);
      wait_empty(40);
      start_op(8'h00, 5'd0, 16'hFE80, 1'b1, 1'b1, 16'h0000, c0);
      wait_empty(40);

      // Reset in cycle 3 of a len=4 run: no out_valid afterwards
      fill_const(16'h0100, 16'h0100);
      start_op(8'h00, 5'd4, 16'h0000, 1'b0, 1'b0, 16'h0000, c0);
      wait_until(c0 + 3);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("abort_busy",   {31'd0, busy},   32'd0);
      chk("abort_result", {16'd0, result}, 32'd0);
      repeat (12) @(negedge clk);

      // Fresh start, start-while-busy ignored, back-to-back start in out_valid cycle
      fill_rand();
      ea = model(8'h20, 2, 16'h0123, 1'b0);
      ec = model(8'h30, 3, 16'hFF00, 1'b1);
      start_op(8'h20, 5'd2, 16'h0123, 1'b0, 1'b1, ea, c0);
      wait_until(c0 + 2);
      start_op(8'h40, 5'd0, 16'h7F00, 1'b1, 1'b0, 16'h0000, c0);
      c0 = c0 - 2;
      wait_until(c0 + 7);
      chk("b2b_idle", {31'd0, busy}, 32'd0);
      start_op(8'h30, 5'd3, 16'hFF00, 1'b1, 1'b1, ec, c0);
      wait_empty(60);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/fc_mac16_acc.md
# fc_mac16_acc

Fully-connected neuron accumulator sitting directly downstream of the 16-wide parallel-read activation RAM. It generates the RAM read address, consumes the 16 consecutive activation words the RAM returns each cycle, and multiplies them lane-wise by 16 weights from a weight memory. It accumulates the products over a programmable number of 16-word blocks, then adds a bias, applies optional ReLU, and emits one saturated Q8.8 neuron output.

## Interface
- DWIDTH, 16, activation/weight/result width, signed Q(DWIDTH-FRAC).FRAC
- AWIDTH, 8, activation RAM and weight memory address width
- FRAC, 8, fractional bits
- ACCW, 40, accumulator width (≥ 2*DWIDTH+4+AWIDTH-4)

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  request; accepted only in IDLE
- base_addr  in  AWIDTH  first activation word address
- len  in  AWIDTH-3  number of 16-word blocks (0..2^(AWIDTH-4))
- bias  in  DWIDTH  signed Q8.8 bias
- relu_en  in  1  clamp negative result to 0
- raddr  out  AWIDTH  activation RAM read address (registered)
- act_flat  in  16*DWIDTH  RAM outputs; lane j = bits [DWIDTH*j+DWIDTH-1 : DWIDTH*j] = word raddr+j
- w_addr  out  AWIDTH  weight memory row address (registered)
- w_flat  in  16*DWIDTH  weight row, same lane layout
- busy  out  1  high whenever state ≠ IDLE
- out_valid  out  1  one-cycle pulse, result valid
- result  out  DWIDTH  signed Q8.8 neuron output, held until next out_valid

## Operation
- FSM: IDLE → RUN (len cycles) → DRAIN (3 cycles) → DONE (1 cycle) → IDLE. len=0 skips RUN (IDLE → DRAIN).
- On start in IDLE: latch base_addr, len, bias, relu_en; clear accumulator; raddr←base_addr; w_addr←0.
- RUN: each cycle present block i (raddr = base+16i mod 2^AWIDTH, w_addr = i); increment both after each cycle. Address wrap is modulo 2^AWIDTH; lane offsets wrap inside the RAM.
- Memories register the address at the edge that ends the cycle in which it is presented, and return data in the following cycle. The block never drives wren; the upstream loader must keep wren low while busy=1.
- Pipeline, valid-tagged: P1 registers 16 signed products (2*DWIDTH each). P2 registers the adder-tree sum (2*DWIDTH+4, sign-extended). P3 adds into acc (ACCW, sign-extended, no overflow possible within len range).
- DONE: t = acc + (sign-extended bias << FRAC); s = t >>> FRAC (arithmetic, truncate toward −∞). Saturate s to [−2^(DWIDTH−1), 2^(DWIDTH−1)−1]; if relu_en and s<0 → 0. Register result and set out_valid.
- start while busy: ignored, no side effects.
- rst (any cycle, including mid-run): state IDLE, pipeline valids 0, acc 0, raddr 0, w_addr 0, busy 0, out_valid 0, result 0. The aborted run produces no out_valid.

## Timing
- Cycle 0: start high in IDLE. Cycles 1..len: RUN, block i presented in cycle i+1 (i = 0..len−1).
- Block i data arrives in cycle i+2. Products are registered at the end of i+2, sum at the end of i+3, acc at the end of i+4.
- Cycles len+1..len+3: DRAIN. Cycle len+4: DONE. out_valid=1 and result updated in cycle len+5; state is IDLE in that cycle.
- Start-to-out_valid latency = len+5 cycles. busy high in cycles 1..len+4.
- A new start is accepted in the out_valid cycle (back-to-back), giving a throughput of one neuron per len+5 cycles.
- raddr and w_addr hold their last value outside RUN.

## Test plan
- All act=0x0100 (1.0), w=0x0100, len=1, base=0, bias=0 → result=0x1000 (16.0); out_valid in cycle 6 only; busy cycles 1–5.
- act=0x0080 (0.5), w=0x0200 (2.0), len=4, bias=0x0100 → result=0x4100 (65.0); raddr sequence 0x00,0x10,0x20,0x30; w_addr 0..3.
- Saturation: act=w=0x7FFF, len=1 → 0x7FFF. w negated, relu_en=0 → 0x8000. Same with relu_en=1 → 0x0000.
- Wrap: base=0xF8, len=2 → raddr 0xF8 then 0x08; accumulated lanes match the RAM contents at the wrapped addresses.
- len=0, bias=0xFE80 (−1.5), relu_en=0 → result=0xFE80, out_valid in cycle 5. Repeat with relu_en=1 → 0x0000.
- rst in cycle 3 of a len=4 run → busy=0 and result=0 next cycle, no out_valid. Start during busy ignored. A fresh start after reset gives correct result and latency.
